// File: rtl/fifo_pack_pkg.sv
// Shared types and default sizing for the FIFO read-side packer.
package fifo_pack_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned RATIO = 4;

  typedef logic [$clog2(RATIO):0]  lane_cnt_t;
  typedef logic [WIDTH*RATIO-1:0]  word_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_e;

endpackage

// File: rtl/pack_flush_timer.sv
// Idle-cycle counter for the packer; raises a flush request once TIMEOUT idle cycles have elapsed.
module pack_flush_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle_i,
  input  logic ack_i,
  output logic flush_req_o
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

  logic [TW-1:0] timer_q, timer_d;
  logic          flush_req_q, flush_req_d;

  // Saturating count of consecutive idle cycles; an accepted flush restarts it.
  always_comb begin
    timer_d = '0;
    if (idle_i && !ack_i) begin
      if (timer_q != TIMEOUT_C) begin
        timer_d = timer_q + TW'(1);
      end else begin
        timer_d = timer_q;
      end
    end
    flush_req_d = (timer_d == TIMEOUT_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q     <= '0;
      flush_req_q <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      flush_req_q <= flush_req_d;
    end
  end

  assign flush_req_o = flush_req_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops WIDTH-bit FIFO entries and packs RATIO of them into one valid/ready word, lane 0 oldest.
// Define PACK_FLUSH_EN to build the idle timer that flushes a partial word after TIMEOUT cycles.
module fifo_rd_packer
  import fifo_pack_pkg::*;
#(
  parameter int unsigned WIDTH = fifo_pack_pkg::WIDTH,
  parameter int unsigned RATIO = fifo_pack_pkg::RATIO
`ifdef PACK_FLUSH_EN
  ,
  parameter int unsigned TIMEOUT = 16
`endif
) (
  input  logic                     r_clk,
  input  logic                     r_rst,
  input  logic                     empty,
  output logic                     rd,
  input  logic [WIDTH-1:0]         rd_data,
  output logic [WIDTH*RATIO-1:0]   out_data,
  output logic [$clog2(RATIO):0]   out_cnt,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int unsigned CW = $clog2(RATIO) + 1;
  localparam int unsigned LW = $clog2(RATIO);
  localparam logic [CW-1:0] RATIO_C = CW'(RATIO);

  logic [RATIO-1:0][WIDTH-1:0] acc_q, acc_d;
  logic [RATIO-1:0][WIDTH-1:0] out_data_q, out_data_d;
  logic [RATIO-1:0][WIDTH-1:0] flush_word_c;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [CW-1:0]               out_cnt_q, out_cnt_d;
  logic                        pend_q, pend_d;
  logic                        out_valid_q, out_valid_d;
  pack_state_e                 state_q, state_d;

  logic xfer_c;
  logic flush_c;
  logic rd_c;

`ifdef PACK_FLUSH_EN
  logic idle_c;
  logic flush_req;

  // Idle means a partial word is parked with nothing in flight and nothing to pop.
  assign idle_c = (cnt_q != '0) && (cnt_q < RATIO_C) && !pend_q && empty;

  pack_flush_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_flush_timer (
    .clk         (r_clk),
    .rst_n       (r_rst),
    .idle_i      (idle_c),
    .ack_i       (flush_c),
    .flush_req_o (flush_req)
  );

  assign flush_c = flush_req && (!out_valid_q || out_ready);
`else
  assign flush_c = 1'b0;
`endif

  assign xfer_c = (state_q == HOLD) && (!out_valid_q || out_ready);

  // Never pop more than the accumulator can still take, counting the entry already in flight.
  assign rd_c = !empty && !flush_c && (((cnt_q + CW'(pend_q)) < RATIO_C) || xfer_c);
  assign rd   = rd_c;

  // Partial word for a flush: lanes not yet filled read as zero.
  always_comb begin
    flush_word_c = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (CW'(i) < cnt_q) begin
        flush_word_c[i] = acc_q[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = rd_c;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = out_valid_q;

    if (pend_q) begin
      acc_d[cnt_q[LW-1:0]] = rd_data;
      cnt_d                = cnt_q + CW'(1);
    end

    if (xfer_c) begin
      out_data_d  = acc_q;
      out_cnt_d   = RATIO_C;
      out_valid_d = 1'b1;
      cnt_d       = '0;
    end else if (flush_c) begin
      out_data_d  = flush_word_c;
      out_cnt_d   = cnt_q;
      out_valid_d = 1'b1;
      cnt_d       = '0;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      FILL:    if (cnt_d == RATIO_C) state_d = HOLD;
      HOLD:    if (xfer_c)           state_d = FILL;
      default:                       state_d = FILL;
    endcase
  end

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_cnt   = out_cnt_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a simple FIFO model and an output-handshake monitor.
module tb_fifo_rd_packer;

  logic        r_clk = 1'b0;
  logic        r_rst = 1'b0;
  logic        empty;
  logic        rd;
  logic [7:0]  rd_data = 8'h00;
  logic [31:0] out_data;
  logic [2:0]  out_cnt;
  logic        out_valid;
  logic        out_ready = 1'b0;

  always #5 r_clk = ~r_clk;

`ifdef PACK_FLUSH_EN
  fifo_rd_packer #(.WIDTH(8), .RATIO(4), .TIMEOUT(16)) dut (
`else
  fifo_rd_packer #(.WIDTH(8), .RATIO(4)) dut (
`endif
    .r_clk     (r_clk),
    .r_rst     (r_rst),
    .empty     (empty),
    .rd        (rd),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // FIFO model: registered read data one cycle after rd && !empty.
  logic [7:0] mem [256];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  logic       gate   = 1'b0;

  assign empty = (wr_ptr == rd_ptr) || gate;

  always @(posedge r_clk) begin
    if (rd && !empty) begin
      rd_data <= mem[rd_ptr];
      rd_ptr  <= rd_ptr + 8'd1;
    end
  end

  int cyc = 0;
  always @(posedge r_clk) cyc <= cyc + 1;

  logic [31:0] got_data [$];
  logic [2:0]  got_cnt  [$];
  int          got_cyc  [$];
  int          rd_cnt = 0;

  always @(negedge r_clk) begin
    if (r_rst) begin
      if (rd) rd_cnt = rd_cnt + 1;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_cnt.push_back(out_cnt);
        got_cyc.push_back(cyc);
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge r_clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr      = wr_ptr + 8'd1;
  endtask

  task automatic clear_mon();
    got_data.delete();
    got_cnt.delete();
    got_cyc.delete();
    rd_cnt = 0;
  endtask

  task automatic wait_words(input int n, input int budget, input string name);
    int k = 0;
    while (got_data.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (got_data.size() < n) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: got %0d words, expected %0d", name, got_data.size(), n);
    end
  endtask

  function automatic logic [31:0] word_at(input int i);
    return (i < got_data.size()) ? got_data[i] : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] cnt_at(input int i);
    return (i < got_cnt.size()) ? {29'd0, got_cnt[i]} : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] cyc_at(input int i);
    return (i < got_cyc.size()) ? 32'(got_cyc[i]) : 32'hxxxxxxxx;
  endfunction

  typedef struct packed {
    logic [7:0]  e0;
    logic [7:0]  e1;
    logic [7:0]  e2;
    logic [7:0]  e3;
    logic [31:0] word;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int start;

    vecs[0] = '{e0: 8'h11, e1: 8'h22, e2: 8'h33, e3: 8'h44, word: 32'h44332211};
    vecs[1] = '{e0: 8'hFF, e1: 8'h00, e2: 8'hFF, e3: 8'h00, word: 32'h00FF00FF};
    vecs[2] = '{e0: 8'h80, e1: 8'h01, e2: 8'h7F, e3: 8'hFE, word: 32'hFE7F0180};
    vecs[3] = '{e0: 8'hDE, e1: 8'hAD, e2: 8'hBE, e3: 8'hEF, word: 32'hEFBEADDE};

    // Reset state
    tick(3);
    check("reset rd",        {31'd0, rd},        32'd0);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset out_data",  out_data,           32'd0);
    check("reset out_cnt",   {29'd0, out_cnt},   32'd0);
    r_rst = 1'b1;
    tick(2);

    // Single words, out_ready held high
    for (int v = 0; v < 4; v++) begin
      clear_mon();
      out_ready = 1'b1;
      push(vecs[v].e0);
      push(vecs[v].e1);
      push(vecs[v].e2);
      push(vecs[v].e3);
      wait_words(1, 40, $sformatf("vec%0d", v));
      tick(3);
      check($sformatf("vec%0d data", v),   word_at(0),           vecs[v].word);
      check($sformatf("vec%0d cnt", v),    cnt_at(0),            32'd4);
      check($sformatf("vec%0d rd", v),     32'(rd_cnt),          32'd4);
      check($sformatf("vec%0d words", v),  32'(got_data.size()), 32'd1);
    end

    // Streaming throughput: one word per RATIO+1 cycles
    clear_mon();
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    wait_words(2, 60, "stream");
    check("stream w0",  word_at(0), 32'h13121110);
    check("stream w1",  word_at(1), 32'h17161514);
    check("stream gap", cyc_at(1) - cyc_at(0), 32'd5);

    // Back-pressure: both words assembled, rd held low in HOLD, then back-to-back release
    clear_mon();
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) push(8'(i));
    tick(15);
    check("hold valid", {31'd0, out_valid}, 32'd1);
    check("hold data",  out_data,           32'h04030201);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (rd !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h04030201 || out_cnt !== 3'd4) bad++;
      tick();
    end
    check("hold stable cycles bad", 32'(bad), 32'd0);
    out_ready = 1'b1;
    wait_words(2, 10, "release");
    check("release w0",  word_at(0), 32'h04030201);
    check("release w1",  word_at(1), 32'h08070605);
    check("release gap", cyc_at(1) - cyc_at(0), 32'd1);
    push(8'h0A);
    push(8'h0B);
    push(8'h0C);
    wait_words(3, 40, "tail");
    check("tail w2", word_at(2), 32'h0C0B0A09);

    // Empty toggling mid-word
    tick(3);
    clear_mon();
    push(8'hA0);
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    for (int k = 0; k < 40 && got_data.size() < 1; k++) begin
      gate = ~gate;
      tick();
    end
    gate = 1'b0;
    wait_words(1, 10, "toggle");
    tick(3);
    check("toggle data",  word_at(0),           32'hA3A2A1A0);
    check("toggle cnt",   cnt_at(0),            32'd4);
    check("toggle rd",    32'(rd_cnt),          32'd4);
    check("toggle words", 32'(got_data.size()), 32'd1);

    // Reset with two lanes captured and one pop in flight
    clear_mon();
    push(8'h90);
    push(8'h91);
    push(8'h92);
    tick(3);
    r_rst = 1'b0;
    #1;
    check("midrst rd",        {31'd0, rd},        32'd0);
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst out_data",  out_data,           32'd0);
    check("midrst out_cnt",   {29'd0, out_cnt},   32'd0);
    tick(2);
    r_rst = 1'b1;
    tick(2);
    clear_mon();
    push(8'hB0);
    push(8'hB1);
    push(8'hB2);
    push(8'hB3);
    wait_words(1, 40, "postrst");
    tick(2);
    check("postrst data",  word_at(0),           32'hB3B2B1B0);
    check("postrst cnt",   cnt_at(0),            32'd4);
    check("postrst words", 32'(got_data.size()), 32'd1);

    // Partial word left idle
    clear_mon();
    start = cyc;
    push(8'hC1);
    push(8'hC2);
`ifdef PACK_FLUSH_EN
    wait_words(1, 80, "flush");
    check("flush data", word_at(0), 32'h0000C2C1);
    check("flush cnt",  cnt_at(0),  32'd2);
    check("flush latency in range",
          {31'd0, (cyc_at(0) >= 32'(start + 16)) && (cyc_at(0) <= 32'(start + 24))}, 32'd1);
`else
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid !== 1'b0) bad++;
      tick();
    end
    check("noflush valid cycles", 32'(bad),             32'd0);
    check("noflush words",        32'(got_data.size()), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
